// File: rtl/vnu_sched_if.sv
// vnu_sched_if: groups the scheduler's start/status, RAM read, write-back and
// decision signals.
//   master: scheduler side (drives busy/done/rd_*/q_we/q_waddr/q_wdata/dec_vec)
//   slave : environment side (drives start, RAM read data, q_ready)
interface vnu_sched_if #(
  parameter int data_w = 8,
  parameter int D      = 12,
  parameter int N      = 6,
  parameter int ext_w  = 3
);
  localparam int sum_w  = data_w + ext_w;
  localparam int addr_w = (N > 1) ? $clog2(N) : 1;

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    rd_en;
  logic [addr_w-1:0]       rd_addr;
  logic [data_w-1:0]       l_rdata;
  logic [data_w*D-1:0]     r_rdata;
  logic                    q_we;
  logic                    q_ready;
  logic [addr_w-1:0]       q_waddr;
  logic [sum_w*D-1:0]      q_wdata;
  logic [N-1:0]            dec_vec;

  modport master (
    input  start, l_rdata, r_rdata, q_ready,
    output busy, done, rd_en, rd_addr, q_we, q_waddr, q_wdata, dec_vec
  );

  modport slave (
    output start, l_rdata, r_rdata, q_ready,
    input  busy, done, rd_en, rd_addr, q_we, q_waddr, q_wdata, dec_vec
  );
endinterface

// File: rtl/vnu_sched.sv
// vnu_sched: time-multiplexes one combinational VNU over N columns per run.
// Latency: column k issued at cycle k+1 after start, written at k+3; done at N+3 unstalled.
// Backpressure: q_we && !q_ready freezes S2, S1 and the issue counter (RAM output held).
// Ports: clk, rst (sync, active-high), bus (vnu_sched_if.master).
// Optional feature: define VNU_SCHED_SAT_EN to clamp each q field to the
// symmetric data_w range before registering it.
module vnu_sched #(
  parameter int data_w = 8,
  parameter int D      = 12,
  parameter int N      = 6,
  parameter int ext_w  = 3
) (
  input  logic          clk,
  input  logic          rst,
  vnu_sched_if.master   bus
);
  localparam int sum_w  = data_w + ext_w;
  localparam int addr_w = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [addr_w-1:0] LAST_COL = addr_w'(N - 1);

`ifdef VNU_SCHED_SAT_EN
  localparam logic signed [sum_w-1:0] QMAX = sum_w'((2 ** (data_w - 1)) - 1);
  localparam logic signed [sum_w-1:0] QMIN = -QMAX;
`endif

  logic [1:0]          state_q, state_d;
  logic [addr_w-1:0]   cnt_q, cnt_d;
  logic                s1_vld_q, s1_vld_d;
  logic [addr_w-1:0]   s1_addr_q, s1_addr_d;
  logic                q_we_q, q_we_d;
  logic [addr_w-1:0]   q_waddr_q, q_waddr_d;
  logic [sum_w*D-1:0]  q_wdata_q, q_wdata_d;
  logic                dec_q, dec_d;
  logic [N-1:0]        dec_vec_q, dec_vec_d;

  logic stall, issue, accept;

  // Shared VNU datapath, fed directly from the RAM output (S1).
  logic [sum_w-1:0]    s_c;
  logic [sum_w-1:0]    q_i;
  logic [sum_w*D-1:0]  q_c;

  function automatic logic [sum_w-1:0] sext(input logic [data_w-1:0] x);
    return {{ext_w{x[data_w-1]}}, x};
  endfunction

  always_comb begin
    s_c = sext(bus.l_rdata);
    q_i = '0;
    q_c = '0;
    for (int i = 0; i < D; i++) begin
      s_c = s_c + sext(bus.r_rdata[i*data_w +: data_w]);
    end
    for (int i = 0; i < D; i++) begin
      q_i = s_c - sext(bus.r_rdata[i*data_w +: data_w]);
`ifdef VNU_SCHED_SAT_EN
      if ($signed(q_i) > QMAX) begin
        q_i = QMAX;
      end else if ($signed(q_i) < QMIN) begin
        q_i = QMIN;
      end
`endif
      q_c[i*sum_w +: sum_w] = q_i;
    end
  end

  always_comb begin
    stall  = q_we_q && !bus.q_ready;
    accept = q_we_q && bus.q_ready;
    issue  = (state_q == ST_RUN) && !stall;

    state_d   = state_q;
    cnt_d     = cnt_q;
    s1_vld_d  = s1_vld_q;
    s1_addr_d = s1_addr_q;
    q_we_d    = q_we_q;
    q_waddr_d = q_waddr_q;
    q_wdata_d = q_wdata_q;
    dec_d     = dec_q;
    dec_vec_d = dec_vec_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          dec_vec_d = '0;
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (cnt_q == LAST_COL) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Leave once S1 is empty and S2 is empty or retiring this cycle.
        if (!s1_vld_q && (!q_we_q || bus.q_ready)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // S1 tracks the RAM read; during a stall rd_en is low so the RAM output,
    // and therefore S1, stays valid.
    if (!stall) begin
      s1_vld_d  = issue;
      s1_addr_d = cnt_q;
      q_we_d    = s1_vld_q;
      if (s1_vld_q) begin
        q_waddr_d = s1_addr_q;
        q_wdata_d = q_c;
        dec_d     = s_c[sum_w-1];
      end
    end

    if (accept) begin
      for (int k = 0; k < N; k++) begin
        if (q_waddr_q == addr_w'(k)) begin
          dec_vec_d[k] = dec_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      q_we_q    <= 1'b0;
      q_waddr_q <= '0;
      q_wdata_q <= '0;
      dec_q     <= 1'b0;
      dec_vec_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      q_we_q    <= q_we_d;
      q_waddr_q <= q_waddr_d;
      q_wdata_q <= q_wdata_d;
      dec_q     <= dec_d;
      dec_vec_q <= dec_vec_d;
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.rd_en   = issue;
  assign bus.rd_addr = cnt_q;
  assign bus.q_we    = q_we_q;
  assign bus.q_waddr = q_waddr_q;
  assign bus.q_wdata = q_wdata_q;
  assign bus.dec_vec = dec_vec_q;
endmodule

// File: tb/tb_vnu_sched.sv
// tb_vnu_sched: table vectors, hand sequences (backpressure, reset, N=1) and
// randomized runs against a cycle-level event model of the scheduler.
module tb_vnu_sched;
  localparam int data_w = 8;
  localparam int D      = 12;
  localparam int N      = 6;
  localparam int ext_w  = 3;
  localparam int sum_w  = data_w + ext_w;
  localparam int MODV   = 1 << sum_w;

`ifdef VNU_SCHED_SAT_EN
  localparam logic [sum_w-1:0] Q_SAT60  = 11'd127;
  localparam logic [sum_w-1:0] Q_MINALL = 11'd127;
`else
  localparam logic [sum_w-1:0] Q_SAT60  = 11'd720;
  localparam logic [sum_w-1:0] Q_MINALL = 11'd512;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vnu_sched_if #(.data_w(data_w), .D(D), .N(N), .ext_w(ext_w)) bus ();
  vnu_sched #(.data_w(data_w), .D(D), .N(N), .ext_w(ext_w)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  vnu_sched_if #(.data_w(data_w), .D(D), .N(1), .ext_w(ext_w)) bus1 ();
  vnu_sched #(.data_w(data_w), .D(D), .N(1), .ext_w(ext_w)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int errors = 0;
  int checks = 0;

  logic [data_w-1:0]   lmem [8];
  logic [data_w*D-1:0] rmem [8];
  logic                rdy_pat [256];

  // Synchronous RAMs; outputs hold when rd_en is low.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.l_rdata <= lmem[bus.rd_addr];
      bus.r_rdata <= rmem[bus.rd_addr];
    end
    if (bus1.rd_en) begin
      bus1.l_rdata <= 8'hFD;
      bus1.r_rdata <= '0;
    end
  end

  task automatic chk(input string name, input logic [sum_w*D-1:0] act,
                     input logic [sum_w*D-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int wrap(input int v);
    int m;
    m = ((v % MODV) + MODV) % MODV;
    return (m >= MODV / 2) ? m - MODV : m;
  endfunction

  function automatic int sx(input logic [data_w-1:0] x);
    return int'($signed(x));
  endfunction

  // Reference: plain integer sums per column.
  function automatic logic [sum_w*D-1:0] model_q(input int k, output logic dec);
    logic [sum_w*D-1:0] res;
    int s, q;
    s = sx(lmem[k]);
    for (int i = 0; i < D; i++) s += sx(rmem[k][i*data_w +: data_w]);
    s = wrap(s);
    dec = (s < 0);
    res = '0;
    for (int i = 0; i < D; i++) begin
      q = wrap(s - sx(rmem[k][i*data_w +: data_w]));
`ifdef VNU_SCHED_SAT_EN
      if (q > 127) q = 127;
      if (q < -127) q = -127;
`endif
      res[i*sum_w +: sum_w] = sum_w'(q);
    end
    return res;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"},    bus.busy,    0);
    chk({tag, "_done"},    bus.done,    0);
    chk({tag, "_rd_en"},   bus.rd_en,   0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 0);
    chk({tag, "_q_we"},    bus.q_we,    0);
    chk({tag, "_q_waddr"}, bus.q_waddr, 0);
    chk({tag, "_q_wdata"}, bus.q_wdata, 0);
    chk({tag, "_dec_vec"}, bus.dec_vec, 0);
  endtask

  // One full run on the N=6 instance. Column k enters S2 at t[k] and leaves
  // at the first ready cycle acc[k]; the next column follows immediately.
  task automatic do_run(input string tag, input int extra_start,
                        output int done_cyc, output logic [sum_w*D-1:0] last_wdata);
    int t [N];
    int acc [N];
    logic [sum_w*D-1:0] eq [N];
    logic [N-1:0] exp_vec;
    logic d;
    int tt, exp_done, rd_cnt, kk;
    tt = 3;
    for (int k = 0; k < N; k++) begin
      t[k] = tt;
      while (!rdy_pat[tt] && tt < 250) tt++;
      acc[k] = tt;
      tt++;
      eq[k] = model_q(k, d);
      exp_vec[k] = d;
    end
    exp_done = tt;
    rd_cnt = 0;
    done_cyc = -1;
    last_wdata = '0;
    for (int c = 0; c <= exp_done + 2; c++) begin
      @(negedge clk);
      bus.start   = (c == 0) || (c == extra_start);
      bus.q_ready = rdy_pat[c];
      #1;
      if (c >= 1) begin
        kk = -1;
        for (int k = 0; k < N; k++) if (c >= t[k] && c <= acc[k]) kk = k;
        chk({tag, "_busy"}, bus.busy, (c <= exp_done));
        chk({tag, "_done"}, bus.done, (c == exp_done));
        if (bus.done) done_cyc = c;
        chk({tag, "_q_we"}, bus.q_we, (kk >= 0));
        if (kk >= 0 && bus.q_we) begin
          chk({tag, "_q_waddr"}, bus.q_waddr, kk);
          chk({tag, "_q_wdata"}, bus.q_wdata, eq[kk]);
          last_wdata = bus.q_wdata;
        end
        if (kk >= 0 && !rdy_pat[c]) chk({tag, "_rd_en_stall"}, bus.rd_en, 0);
        if (bus.rd_en) begin
          chk({tag, "_rd_addr"}, bus.rd_addr, rd_cnt);
          rd_cnt++;
        end
      end
    end
    bus.start   = 1'b0;
    bus.q_ready = 1'b1;
    chk({tag, "_reads"}, rd_cnt, N);
    chk({tag, "_dec_vec"}, bus.dec_vec, exp_vec);
  endtask

  typedef struct {
    logic [data_w-1:0] l;
    logic [data_w-1:0] r;
    logic [sum_w-1:0]  q;
    logic              dec;
  } vec_t;

  task automatic fill_uniform(input logic [data_w-1:0] l, input logic [data_w-1:0] r);
    for (int k = 0; k < 8; k++) begin
      lmem[k] = l;
      rmem[k] = {D{r}};
    end
  endtask

  task automatic ready_all;
    for (int i = 0; i < 256; i++) rdy_pat[i] = 1'b1;
  endtask

  initial begin
    vec_t tbl [4];
    int dc;
    logic [sum_w*D-1:0] lw;

    tbl[0] = '{8'd5,  8'd0,  11'd5,    1'b0};
    tbl[1] = '{8'hEC, 8'd1,  11'h7F7,  1'b1};
    tbl[2] = '{8'd60, 8'd60, Q_SAT60,  1'b0};
    tbl[3] = '{8'h80, 8'h80, Q_MINALL, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.q_ready = 1'b1;
    bus1.start = 1'b0;
    bus1.q_ready = 1'b1;
    ready_all();
    fill_uniform(8'd0, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("reset");

    // Table vectors: same value in every column, no backpressure.
    for (int v = 0; v < 4; v++) begin
      fill_uniform(tbl[v].l, tbl[v].r);
      ready_all();
      do_run($sformatf("tbl%0d", v), -1, dc, lw);
      chk($sformatf("tbl%0d_done_cycle", v), dc, 9);
      chk($sformatf("tbl%0d_q", v), lw, {D{tbl[v].q}});
      chk($sformatf("tbl%0d_decvec", v), bus.dec_vec, {N{tbl[v].dec}});
    end

    // Backpressure: column 2 sits in S2 at cycle 5, ready low for 3 cycles.
    for (int k = 0; k < N; k++) begin
      lmem[k] = 8'(k * 7 - 20);
      rmem[k] = {D{8'(k + 1)}};
    end
    ready_all();
    rdy_pat[5] = 1'b0;
    rdy_pat[6] = 1'b0;
    rdy_pat[7] = 1'b0;
    do_run("bp", -1, dc, lw);
    chk("bp_done_cycle", dc, 12);

    // Start while busy has no effect.
    ready_all();
    do_run("busy_start", 4, dc, lw);
    chk("busy_start_done_cycle", dc, 9);

    // Reset mid-run: cycle 6 shows reset values, no done follows.
    fill_uniform(8'hEC, 8'd1);
    ready_all();
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_done", bus.done, 0);
      chk("midrst_idle", bus.busy, 0);
    end
    do_run("after_rst", -1, dc, lw);
    chk("after_rst_done_cycle", dc, 9);
    chk("after_rst_decvec", bus.dec_vec, 6'b111111);

    // Randomized runs with random data and random backpressure.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) begin
        lmem[k] = 8'($urandom);
        for (int i = 0; i < D; i++) rmem[k][i*data_w +: data_w] = 8'($urandom);
      end
      ready_all();
      for (int i = 0; i < 200; i++) rdy_pat[i] = ($urandom_range(0, 9) >= 3);
      do_run($sformatf("rnd%0d", r), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8)) : -1,
             dc, lw);
    end

    // N=1 with start held for two cycles: one run, done at cycle 4.
    begin
      int rd1, wr1;
      rd1 = 0;
      wr1 = 0;
      @(negedge clk);
      bus1.start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        bus1.start = (c == 1);
        #1;
        chk("n1_busy", bus1.busy, (c <= 4));
        chk("n1_done", bus1.done, (c == 4));
        chk("n1_q_we", bus1.q_we, (c == 3));
        if (bus1.rd_en) rd1++;
        if (bus1.q_we) begin
          wr1++;
          chk("n1_q_waddr", bus1.q_waddr, 0);
          chk("n1_q_wdata", bus1.q_wdata, {D{11'h7FD}});
        end
      end
      chk("n1_reads", rd1, 1);
      chk("n1_writes", wr1, 1);
      chk("n1_decvec", bus1.dec_vec, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
